// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: feeds one M-extension op to muldiv_unit, stalls EX for a fixed window, then writes back
// Ports: clk_i, rst_ni (sync, active-low); req_valid_i, rs1_i, rs2_i, funct3_i, rd_addr_i, flush_i from EX;
//   stall_o to IF/ID/EX; md_in1_o, md_in2_o, md_funct3_o to muldiv_unit, md_result_i back from it;
//   wb_valid_o, wb_rd_o, wb_data_o writeback. Optional MULDIV_OPCACHE_EN adds a last-result cache.
module muldiv_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] md_in1_o,
  output logic [XLEN-1:0] md_in2_o,
  output logic [2:0]      md_funct3_o,
  input  logic [XLEN-1:0] md_result_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);
  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_in1, r_in2, r_wb_data;
  logic [2:0]      r_funct3;
  logic [4:0]      r_wb_rd;
  logic            w_accept, w_finish, w_hit;
  logic [XLEN-1:0] w_hit_data;
  assign w_accept = (r_state == IDLE) & req_valid_i & ~flush_i;
  assign w_finish = (r_state == BUSY) & ~flush_i & (r_cnt == 4'd0);
`ifdef MULDIV_OPCACHE_EN
  logic            r_c_valid;
  logic [XLEN-1:0] r_c_in1, r_c_in2, r_c_res;
  logic [2:0]      r_c_f3;
  assign w_hit      = r_c_valid & (rs1_i == r_c_in1) & (rs2_i == r_c_in2) & (funct3_i == r_c_f3);
  assign w_hit_data = r_c_res;
  // Results are pure functions of the operands, so a flush never needs to invalidate the entry.
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_c_valid <= 1'b0;
      r_c_in1   <= '0;
      r_c_in2   <= '0;
      r_c_f3    <= '0;
      r_c_res   <= '0;
    end else if (w_finish) begin
      r_c_valid <= 1'b1;
      r_c_in1   <= r_in1;
      r_c_in2   <= r_in2;
      r_c_f3    <= r_funct3;
      r_c_res   <= md_result_i;
    end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_funct3  <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_in1    <= rs1_i;
          r_in2    <= rs2_i;
          r_funct3 <= funct3_i;
          r_wb_rd  <= rd_addr_i;
          if (w_hit) begin
            r_wb_data <= w_hit_data;
            r_state   <= DONE;
          end else begin
            r_cnt   <= funct3_i[2] ? DIV_CNT : MUL_CNT;
            r_state <= BUSY;
          end
        end
        BUSY: if (flush_i) r_state <= IDLE;
          else if (w_finish) begin
            r_wb_data <= md_result_i;
            r_state   <= DONE;
          end else r_cnt <= r_cnt - 4'd1;
        default: r_state <= IDLE;
      endcase
    end
  // In IDLE the stall must rise in the accept cycle itself, before any state has been registered.
  assign stall_o     = (r_state == IDLE) ? w_accept : (r_state == BUSY) & ~flush_i;
  assign wb_valid_o  = (r_state == DONE) & ~flush_i;
  assign md_in1_o    = r_in1;
  assign md_in2_o    = r_in2;
  assign md_funct3_o = r_funct3;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: table-driven, directed and random checks of muldiv_issue_ctrl against a transaction model
module tb_muldiv_issue_ctrl;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;
  logic        clk_i = 1'b0, rst_ni = 1'b0, req_valid_i = 1'b0, flush_i = 1'b0;
  logic [31:0] rs1_i = '0, rs2_i = '0, md_result_i;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_o, wb_valid_o;
  logic [31:0] md_in1_o, md_in2_o, wb_data_o;
  logic [2:0]  md_funct3_o;
  logic [4:0]  wb_rd_o;
  int checks = 0, fails = 0;
  muldiv_issue_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .stall_o(stall_o),
    .md_in1_o(md_in1_o), .md_in2_o(md_in2_o), .md_funct3_o(md_funct3_o), .md_result_i(md_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o));
  always #5 clk_i = ~clk_i;
  // RISC-V M-extension semantics from plain arithmetic; also stands in for muldiv_unit.
  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f)
      3'd1:    p = sa * sb;
      3'd2:    p = sa * $signed({32'd0, b});
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    case (f)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  assign md_result_i = ref_op(md_in1_o, md_in2_o, md_funct3_o);
  // Transaction model: m_age = cycles since accept (-1 when idle), m_lat = stall cycles after accept.
  int          m_age = -1, m_lat = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0, m_wbd = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_wbrd = '0;
`ifdef MULDIV_OPCACHE_EN
  logic        c_v = 1'b0;
  logic [31:0] c_a = '0, c_b = '0;
  logic [2:0]  c_f3 = '0;
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_age = -1; m_a = '0; m_b = '0; m_f3 = '0; m_wbd = '0; m_wbrd = '0;
`ifdef MULDIV_OPCACHE_EN
    c_v = 1'b0;
`endif
  endtask
  // One cycle: drive inputs at the falling edge, check 1ns later, advance the model, wait to the next falling edge.
  task automatic cyc(input logic req, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                     input logic [4:0] rd, input logic fl, output logic w, output logic s, output logic [31:0] d);
    logic e_st, e_wb;
    bit hit;
    req_valid_i = req; rs1_i = a; rs2_i = b; funct3_i = f3; rd_addr_i = rd; flush_i = fl;
    #1;
    if (m_age < 0) begin e_st = req & ~fl; e_wb = 1'b0; end
    else if (m_age <= m_lat) begin e_st = ~fl; e_wb = 1'b0; end
    else begin e_st = 1'b0; e_wb = ~fl; end
    chk("stall", 32'(stall_o), 32'(e_st));
    chk("wb_valid", 32'(wb_valid_o), 32'(e_wb));
    chk("wb_data", wb_data_o, m_wbd);
    chk("wb_rd", 32'(wb_rd_o), 32'(m_wbrd));
    chk("md_in1", md_in1_o, m_a);
    chk("md_in2", md_in2_o, m_b);
    chk("md_funct3", 32'(md_funct3_o), 32'(m_f3));
    w = wb_valid_o; s = stall_o; d = wb_data_o;
    if (m_age < 0) begin
      if (req && !fl) begin
        m_a = a; m_b = b; m_f3 = f3; m_wbrd = rd; m_res = ref_op(a, b, f3);
        hit = 1'b0;
`ifdef MULDIV_OPCACHE_EN
        hit = c_v && a == c_a && b == c_b && f3 == c_f3;
`endif
        m_lat = hit ? 0 : (f3[2] ? DIV_LAT : MUL_LAT);
        if (hit) m_wbd = m_res;
        m_age = 1;
      end
    end else if (m_age <= m_lat) begin
      if (fl) m_age = -1;
      else begin
        if (m_age == m_lat) begin
          m_wbd = m_res;
`ifdef MULDIV_OPCACHE_EN
          c_v = 1'b1; c_a = m_a; c_b = m_b; c_f3 = m_f3;
`endif
        end
        m_age++;
      end
    end else m_age = -1;
    @(negedge clk_i);
  endtask
  // Present one instruction until its writeback appears (bounded), then check data and stall count.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int stalls);
    logic w, s;
    logic [31:0] d, got;
    int n;
    bit seen;
    n = 0; seen = 1'b0; got = 'x;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b1, a, b, f3, rd, 1'b0, w, s, d);
      n += int'(s);
      if (w) begin seen = 1'b1; got = d; end
    end
    chk({nm, "_wb_seen"}, 32'(seen), 32'd1);
    chk({nm, "_data"}, got, exp);
    chk({nm, "_stalls"}, 32'(n), 32'(stalls));
  endtask
  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          stalls;
  } vec_t;
  vec_t tbl[9];
  logic        tw, ts;
  logic [31:0] td, ra, rb;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{"mul_7x6",       3'd0, 32'd7,        32'd6,        5'd5,  32'd42,        MUL_LAT + 1};
    tbl[1] = '{"div_100_7",     3'd4, 32'd100,      32'd7,        5'd6,  32'd14,        DIV_LAT + 1};
    tbl[2] = '{"rem_100_7",     3'd6, 32'd100,      32'd7,        5'd7,  32'd2,         DIV_LAT + 1};
    tbl[3] = '{"mulhu_max",     3'd3, 32'hffffffff, 32'hffffffff, 5'd8,  32'hfffffffe,  MUL_LAT + 1};
    tbl[4] = '{"mul_2x3_b2b",   3'd0, 32'd2,        32'd3,        5'd9,  32'd6,         MUL_LAT + 1};
    tbl[5] = '{"divu_by0",      3'd5, 32'h10,       32'd0,        5'd10, 32'hffffffff,  DIV_LAT + 1};
    tbl[6] = '{"remu_17_5",     3'd7, 32'd17,       32'd5,        5'd11, 32'd2,         DIV_LAT + 1};
    tbl[7] = '{"div_ovf",       3'd4, 32'h80000000, 32'hffffffff, 5'd12, 32'h80000000,  DIV_LAT + 1};
    tbl[8] = '{"mulhsu_m1x2",   3'd2, 32'hffffffff, 32'd2,        5'd13, 32'hffffffff,  MUL_LAT + 1};
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_md_in1", md_in1_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 9; i++) run_op(tbl[i].nm, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].stalls);
    // DIVU killed by a flush in its second BUSY cycle, then MUL 3*3.
    cyc(1'b1, 32'h10, 32'd0, 3'd5, 5'd3, 1'b0, tw, ts, td);
    cyc(1'b1, 32'h10, 32'd0, 3'd5, 5'd3, 1'b0, tw, ts, td);
    cyc(1'b1, 32'h10, 32'd0, 3'd5, 5'd3, 1'b1, tw, ts, td);
    chk("flush_stall_low", 32'(ts), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, tw, ts, td);
    chk("flush_no_wb", 32'(tw), 32'd0);
    run_op("mul_3x3_after_flush", 3'd0, 32'd3, 32'd3, 5'd4, 32'd9, MUL_LAT + 1);
    // Reset in the middle of a DIV.
    cyc(1'b1, 32'd100, 32'd7, 3'd4, 5'd9, 1'b0, tw, ts, td);
    cyc(1'b1, 32'd100, 32'd7, 3'd4, 5'd9, 1'b0, tw, ts, td);
    rst_ni = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("midrst_wb_data", wb_data_o, 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd_o), 32'd0);
    chk("midrst_md_in1", md_in1_o, 32'd0);
    chk("midrst_md_in2", md_in2_o, 32'd0);
    chk("midrst_md_funct3", 32'(md_funct3_o), 32'd0);
    m_reset();
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, tw, ts, td);
    // MULH -2*3 twice: a cache hit shortens the repeat to one stall cycle.
    run_op("mulh_first", 3'd1, 32'hfffffffe, 32'd3, 5'd14, 32'hffffffff, MUL_LAT + 1);
`ifdef MULDIV_OPCACHE_EN
    run_op("mulh_repeat", 3'd1, 32'hfffffffe, 32'd3, 5'd15, 32'hffffffff, 1);
`else
    run_op("mulh_repeat", 3'd1, 32'hfffffffe, 32'd3, 5'd15, 32'hffffffff, MUL_LAT + 1);
`endif
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cyc($urandom_range(0, 3) != 0, ra, rb, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
          $urandom_range(0, 9) == 0, tw, ts, td);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
